alsu_driver: RTL and testbench
==============================

# alsu_driver

Command-side initiator for the ALSU core. Accepts one operation at a time over a valid/ready command port and drives the ALSU input pins with it. Captures the ALSU result (`out`, `invalid`) after a fixed pipeline latency and returns it over a valid/ready response port. Sits between the test/host sequencer and the ALSU instance; it keeps a saturating count of invalid results.

## Interface
Parameters:
- `ALSU_LATENCY`, default 2: cycles from ALSU inputs changing to the matching `out`/`invalid` being valid. The ALSU has an input register and an output register.
- `CNT_W`, default 8: width of the invalid-result counter.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_a` in 3: signed operand A.
- `cmd_b` in 3: signed operand B.
- `cmd_opcode` in 3: ALSU opcode.
- `cmd_flags` in 7: `alsu_flags_t` {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}.
- `alsu_A`, `alsu_B` out 3 each: driven to the ALSU.
- `alsu_opcode` out 3: driven to the ALSU.
- `alsu_cin`, `alsu_serial_in`, `alsu_direction`, `alsu_red_op_A`, `alsu_red_op_B`, `alsu_bypass_A`, `alsu_bypass_B` out 1 each: driven to the ALSU.
- `alsu_out` in 6 signed: ALSU result.
- `alsu_invalid` in 1: ALSU invalid flag.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_out` out 6 signed: captured result.
- `rsp_invalid` out 1: captured invalid flag.
- `invalid_cnt` out CNT_W: saturating count of captured invalid results.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - `cmd_ready` = (state == IDLE).
  - `busy` = (state != IDLE).
- IDLE:
  - On `cmd_valid && cmd_ready`, register all command fields into the `alsu_*` output registers.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - When the counter reaches `ALSU_LATENCY`, register `alsu_out` → `rsp_out` and `alsu_invalid` → `rsp_invalid`.
  - On that same edge, increment `invalid_cnt` if `alsu_invalid` = 1, and go to RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_out` and `rsp_invalid` are held stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `alsu_*` outputs hold the last command until the next accepted command.
  - Continued shift/rotate activity after capture is permitted and not observed.
- Commands are passed through unchecked. Opcodes 6 and 7 are driven as-is; the ALSU flags them as invalid.
- `invalid_cnt` saturates at 2^CNT_W−1 and never wraps. It is cleared only by reset.
- `cmd_valid` during WAIT or RESP is not accepted (`cmd_ready` = 0). The command must stay held by the source.
- Reset values: state IDLE, `cmd_ready` 1, `busy` 0, `rsp_valid` 0, `rsp_out` 0, `rsp_invalid` 0, all `alsu_*` 0, `invalid_cnt` 0.
- Reset during WAIT or RESP:
  - The pending command and response are discarded.
  - No response is emitted after `rst_n` rises.

## Timing
- Command handshake in cycle T:
  - `alsu_*` carry the command from T+1.
  - The result is sampled at the end of cycle T+1+ALSU_LATENCY.
  - `rsp_valid` = 1 from cycle T+2+ALSU_LATENCY (T+4 at default).
- `cmd_ready` = 0 from T+1 through the response handshake cycle. It returns to 1 in the cycle after the `rsp` handshake.
- Minimum command spacing: ALSU_LATENCY+3 cycles when `rsp_ready` is tied high.
- `rsp_out`/`rsp_invalid` must not change while `rsp_valid && !rsp_ready`.

## Structure
- Shared package `alsu_pkg`:
  - `opcode_e`: OP_AND=0, OP_XOR=1, OP_ADD=2, OP_MULT=3, OP_SHIFT=4, OP_ROTATE=5, OP_INV6=6, OP_INV7=7.
  - `alsu_flags_t` packed struct.
  - `drv_state_e`.
  - Widths `ALSU_IN_W`=3 and `ALSU_OUT_W`=6.
- Single module. No sub-module is needed.
- The saturating counter and the FSM stay inline.

## Test plan
- Reset:
  - Stimulus: assert `rst_n`=0 mid-cycle.
  - Required: outputs go to their reset values immediately, with no clock edge needed. `cmd_ready`=1, `rsp_valid`=0, `invalid_cnt`=0.
- ADD:
  - Stimulus: A=3, B=2, cin=0, handshake at T.
  - Required: `alsu_A`=3 and `alsu_opcode`=2 from T+1; `rsp_valid` at T+4 with `rsp_out`=5 and `rsp_invalid`=0; `cmd_ready`=0 over T+1..T+4.
- MULT:
  - Stimulus: A=−4, B=3.
  - Required: `rsp_out`=−12, `rsp_invalid`=0, `invalid_cnt` unchanged.
- Invalid opcode:
  - Stimulus: opcode 6.
  - Required: `rsp_invalid`=1, `rsp_out`=0, `invalid_cnt` 0→1.
  - Then 300 further opcode-7 commands → `invalid_cnt`=255 (saturated).
- Backpressure:
  - Stimulus: `rsp_ready`=0 for 5 cycles while `cmd_valid`=1.
  - Required: `rsp_out` stable, no command accepted. The next command is accepted in the cycle after the `rsp` handshake.
- Reset in WAIT:
  - Stimulus: `rst_n` low at T+2 for 1 cycle.
  - Required: `rsp_valid` stays 0, state IDLE, `alsu_*`=0, the next command behaves normally.

Source files
------------

// File: rtl/alsu_pkg.sv
// Shared types for the ALSU driver: opcodes, command flag bundle, driver states.
package alsu_pkg;

    localparam int ALSU_IN_W  = 3;
    localparam int ALSU_OUT_W = 6;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MULT   = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } opcode_e;

    typedef struct packed {
        logic cin;
        logic serial_in;
        logic direction;
        logic red_op_A;
        logic red_op_B;
        logic bypass_A;
        logic bypass_B;
    } alsu_flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } drv_state_e;

endpackage

// File: rtl/alsu_driver.sv
// Command-side initiator for the ALSU: drives one operation, captures the result
// after the ALSU pipeline latency and returns it on a valid/ready response port.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a command; alsu_* hold the last accepted command
// ST_WAIT | counting ALSU pipeline latency before sampling the result
// ST_RESP | response held on rsp_* until the consumer takes it
module alsu_driver
    import alsu_pkg::*;
#(
    parameter int ALSU_LATENCY = 2,
    parameter int CNT_W        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic        [ALSU_IN_W-1:0]  cmd_a,
    input  logic        [ALSU_IN_W-1:0]  cmd_b,
    input  logic        [2:0]            cmd_opcode,
    input  logic        [6:0]            cmd_flags,
    output logic signed [ALSU_IN_W-1:0]  alsu_A,
    output logic signed [ALSU_IN_W-1:0]  alsu_B,
    output logic        [2:0]            alsu_opcode,
    output logic                         alsu_cin,
    output logic                         alsu_serial_in,
    output logic                         alsu_direction,
    output logic                         alsu_red_op_A,
    output logic                         alsu_red_op_B,
    output logic                         alsu_bypass_A,
    output logic                         alsu_bypass_B,
    input  logic signed [ALSU_OUT_W-1:0] alsu_out,
    input  logic                         alsu_invalid,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [ALSU_OUT_W-1:0] rsp_out,
    output logic                         rsp_invalid,
    output logic        [CNT_W-1:0]      invalid_cnt,
    output logic                         busy
);

    // Wide enough to hold ALSU_LATENCY, also for a latency of 0.
    localparam int WCW = $clog2(ALSU_LATENCY + 2);
    localparam logic [WCW-1:0] LAT_TC = WCW'(ALSU_LATENCY);

    drv_state_e                  r_state;
    logic        [WCW-1:0]       r_cnt;
    logic        [ALSU_IN_W-1:0] r_a;
    logic        [ALSU_IN_W-1:0] r_b;
    logic        [2:0]           r_opcode;
    alsu_flags_t                 r_flags;
    logic                        r_rsp_valid;
    logic        [ALSU_OUT_W-1:0] r_rsp_out;
    logic                        r_rsp_invalid;
    logic        [CNT_W-1:0]     r_inv_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_opcode      <= '0;
            r_flags       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_out     <= '0;
            r_rsp_invalid <= 1'b0;
            r_inv_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_a      <= cmd_a;
                        r_b      <= cmd_b;
                        r_opcode <= cmd_opcode;
                        r_flags  <= alsu_flags_t'(cmd_flags);
                        r_cnt    <= '0;
                        r_state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == LAT_TC) begin
                        r_rsp_out     <= alsu_out;
                        r_rsp_invalid <= alsu_invalid;
                        r_rsp_valid   <= 1'b1;
                        // Saturate instead of wrapping so a flood of bad ops stays visible.
                        if (alsu_invalid && (r_inv_cnt != {CNT_W{1'b1}})) begin
                            r_inv_cnt <= r_inv_cnt + CNT_W'(1);
                        end
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + WCW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready      = (r_state == ST_IDLE);
    assign busy           = (r_state != ST_IDLE);
    assign alsu_A         = r_a;
    assign alsu_B         = r_b;
    assign alsu_opcode    = r_opcode;
    assign alsu_cin       = r_flags.cin;
    assign alsu_serial_in = r_flags.serial_in;
    assign alsu_direction = r_flags.direction;
    assign alsu_red_op_A  = r_flags.red_op_A;
    assign alsu_red_op_B  = r_flags.red_op_B;
    assign alsu_bypass_A  = r_flags.bypass_A;
    assign alsu_bypass_B  = r_flags.bypass_B;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_out        = r_rsp_out;
    assign rsp_invalid    = r_rsp_invalid;
    assign invalid_cnt    = r_inv_cnt;

endmodule

// File: tb/tb_alsu_driver.sv
// Directed bench for alsu_driver with a two-stage ALSU stand-in and a result scoreboard.
module tb_alsu_driver;
    import alsu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_a = '0;
    logic [2:0] cmd_b = '0;
    logic [2:0] cmd_opcode = '0;
    logic [6:0] cmd_flags = '0;
    logic [2:0] alsu_A, alsu_B, alsu_opcode;
    logic       alsu_cin, alsu_serial_in, alsu_direction;
    logic       alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [5:0] alsu_out;
    logic       alsu_invalid;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [5:0] rsp_out;
    logic       rsp_invalid;
    logic [7:0] invalid_cnt;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    logic [6:0] sb_q[$];

    always #5 clk = ~clk;

    alsu_driver #(.ALSU_LATENCY(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_flags(cmd_flags),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
        .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_out(alsu_out), .alsu_invalid(alsu_invalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_invalid(rsp_invalid),
        .invalid_cnt(invalid_cnt), .busy(busy)
    );

    // Reference ALSU behaviour for the ops exercised here: {invalid, out}.
    function automatic logic [6:0] alsu_fn(input logic [2:0] a, input logic [2:0] b,
                                           input logic [2:0] op, input logic cin);
        logic signed [5:0] sa, sb, r;
        logic inv;
        sa  = {{3{a[2]}}, a};
        sb  = {{3{b[2]}}, b};
        r   = '0;
        inv = 1'b0;
        case (op)
            3'd0: r = sa & sb;
            3'd1: r = sa ^ sb;
            3'd2: r = sa + sb + {5'd0, cin};
            3'd3: r = sa * sb;
            3'd6, 3'd7: inv = 1'b1;
            default: r = '0;
        endcase
        return {inv, r};
    endfunction

    // ALSU stand-in: input register then output register (latency 2).
    logic [2:0] m_a = '0, m_b = '0, m_op = '0;
    logic       m_cin = 1'b0;
    logic [6:0] m_res = '0;
    always @(posedge clk) begin
        m_a   <= alsu_A;
        m_b   <= alsu_B;
        m_op  <= alsu_opcode;
        m_cin <= alsu_cin;
        m_res <= alsu_fn(m_a, m_b, m_op, m_cin);
    end
    assign alsu_out     = m_res[5:0];
    assign alsu_invalid = m_res[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for cmd_ready, hands the command over, checks the alsu_* pins and
    // returns once rsp_valid is seen (or the cycle budget expires).
    task automatic send_cmd(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                            input logic [6:0] fl, output int wait_cyc);
        int cyc;
        cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_flags = fl;
        cmd_valid = 1'b1;
        wait_cyc = 0;
        while (!cmd_ready && wait_cyc < 50) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        sb_q.push_back(alsu_fn(a, b, op, fl[6]));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("alsu_A", {29'd0, alsu_A}, {29'd0, a});
        chk("alsu_B", {29'd0, alsu_B}, {29'd0, b});
        chk("alsu_opcode", {29'd0, alsu_opcode}, {29'd0, op});
        chk("alsu_flags", {25'd0, alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A,
                           alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, {25'd0, fl});
        chk("busy_T1", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (!rsp_valid && cyc < 20) begin
            chk("cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        chk("rsp_latency", cyc, 32'd4);
        chk("cmd_ready_resp", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic take_rsp(output logic [6:0] got);
        logic [6:0] e;
        got = {rsp_invalid, rsp_out};
        if (sb_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb_q.pop_front();
            chk("rsp_out", {26'd0, rsp_out}, {26'd0, e[5:0]});
            chk("rsp_invalid", {31'd0, rsp_invalid}, {31'd0, e[6]});
            if (e[6] && exp_cnt < 255) exp_cnt++;
            chk("invalid_cnt", {24'd0, invalid_cnt}, 32'(exp_cnt));
        end
    endtask

    task automatic finish_rsp();
        @(posedge clk); #1;
        chk("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        int w;
        logic [6:0] got;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_invalid_cnt", {24'd0, invalid_cnt}, 32'd0);
        chk("rst_alsu_A", {29'd0, alsu_A}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 3+2, then ADD with carry, MULT -4*3, XOR, AND
        send_cmd(3'd3, 3'd2, 3'd2, 7'b0000000, w); take_rsp(got); finish_rsp();
        send_cmd(3'd1, 3'd1, 3'd2, 7'b1000000, w); take_rsp(got); finish_rsp();
        send_cmd(3'b100, 3'd3, 3'd3, 7'b0101010, w); take_rsp(got); finish_rsp();
        chk("mult_value", {26'd0, got[5:0]}, {26'd0, 6'b110100});
        send_cmd(3'b101, 3'b011, 3'd1, 7'b0010101, w); take_rsp(got); finish_rsp();
        send_cmd(3'b110, 3'b011, 3'd0, 7'b0000011, w); take_rsp(got); finish_rsp();

        // invalid opcode 6
        send_cmd(3'd1, 3'd2, 3'd6, 7'b0000000, w); take_rsp(got); finish_rsp();
        chk("inv6_cnt", {24'd0, invalid_cnt}, 32'd1);

        // backpressure with a new command held on the port
        rsp_ready = 1'b0;
        send_cmd(3'd2, 3'd2, 3'd2, 7'b0000000, w); take_rsp(got);
        cmd_a = 3'd1; cmd_b = 3'd3; cmd_opcode = 3'd1; cmd_flags = 7'b0000000;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_stable", {25'd0, rsp_invalid, rsp_out}, {25'd0, got});
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_no_accept", {29'd0, alsu_A}, 32'd2);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_back", {31'd0, cmd_ready}, 32'd1);
        send_cmd(3'd1, 3'd3, 3'd1, 7'b0000000, w);
        chk("bp_accept_wait", w, 32'd0);
        take_rsp(got); finish_rsp();

        // async reset in the middle of a held response
        rsp_ready = 1'b0;
        send_cmd(3'd0, 3'd0, 3'd7, 7'b1111111, w); take_rsp(got);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_invalid_cnt", {24'd0, invalid_cnt}, 32'd0);
        chk("arst_rsp_out", {25'd0, rsp_invalid, rsp_out}, 32'd0);
        chk("arst_alsu_flags", {25'd0, alsu_cin, alsu_serial_in, alsu_direction, alsu_red_op_A,
                                alsu_red_op_B, alsu_bypass_A, alsu_bypass_B}, 32'd0);
        exp_cnt = 0;
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // reset during WAIT: command dropped, no response afterwards
        cmd_a = 3'd3; cmd_b = 3'd3; cmd_opcode = 3'd6; cmd_flags = 7'b0000000;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("wrst_accepted", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("wrst_alsu_A", {29'd0, alsu_A}, 32'd0);
        chk("wrst_alsu_opcode", {29'd0, alsu_opcode}, 32'd0);
        chk("wrst_idle", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("wrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        chk("wrst_cnt", {24'd0, invalid_cnt}, 32'd0);
        send_cmd(3'd3, 3'd2, 3'd2, 7'b0000000, w); take_rsp(got); finish_rsp();

        // saturate the invalid counter
        for (int i = 0; i < 300; i++) begin
            send_cmd(3'(i), 3'(i + 1), 3'd7, 7'b0000000, w); take_rsp(got); finish_rsp();
        end
        chk("cnt_saturated", {24'd0, invalid_cnt}, 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
